// File: rtl/textreme_targets_pkg.sv
// Shared types for the extreme-value target tracker: scan FSM states and
// the max/min tracking mode encoding.
package textreme_targets_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/textreme_targets_extreme_cmp.sv
// Unsigned W-bit comparator deciding whether a new sample replaces the
// running extreme; ties never replace.
module extreme_cmp
    import textreme_targets_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         mode,
    input  logic [W-1:0] sample,
    input  logic [W-1:0] current,
    output logic         take
);

    // Strictly-better test in the selected direction
    always_comb begin
        take = 1'b0;
        if (mode == MODE_MIN) begin
            take = (sample < current);
        end else begin
            take = (sample > current);
        end
    end

endmodule

// File: rtl/textreme_targets.sv
// Per-target extreme tracker: a scan folds samples into a running max/min
// and commits the result into a small register-file of targets.
module textreme_targets
    import textreme_targets_pkg::*;
#(
    parameter int W     = 10,
    parameter int N_TGT = 15,
    parameter int IDX_W = 4,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] number,
    input  logic             start_en,
    input  logic             en,
    input  logic             end_en,
    input  logic             clr,
    input  logic             mode,
    input  logic [W-1:0]     t,
    output logic [W-1:0]     ttemp,
    output logic [W-1:0]     tcmp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    state_t           state_r;
    logic [IDX_W-1:0] num_r;
    logic             mode_r;
    logic [W-1:0]     tcmp_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [W-1:0]     ttemp_r;
    logic [W-1:0]     stored_r [1:N_TGT];
    logic [N_TGT:1]   valid_r;

    logic             num_ok_s;
    logic [W-1:0]     rd_val_s;
    logic             rd_valid_s;
    logic [W-1:0]     seed_s;
    logic             take_s;

    assign num_ok_s = (number != {IDX_W{1'b0}}) && (number <= IDX_W'(N_TGT));

    // Decode the addressed target; out-of-range indices never match
    always_comb begin
        rd_val_s   = {W{1'b0}};
        rd_valid_s = 1'b0;
        for (int i = 1; i <= N_TGT; i++) begin
            rd_val_s   = (number == IDX_W'(i)) ? stored_r[i] : rd_val_s;
            rd_valid_s = (number == IDX_W'(i)) ? valid_r[i]  : rd_valid_s;
        end
    end

    // Scan seed: prior result if present, otherwise the identity of the mode
    always_comb begin
        seed_s = {W{1'b0}};
        if (rd_valid_s) begin
            seed_s = rd_val_s;
        end else if (mode == MODE_MIN) begin
            seed_s = {W{1'b1}};
        end else begin
            seed_s = {W{1'b0}};
        end
    end

    extreme_cmp #(.W(W)) u_cmp (
        .mode    (mode_r),
        .sample  (t),
        .current (tcmp_r),
        .take    (take_s)
    );

    // Scan control FSM with registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            num_r   <= {IDX_W{1'b0}};
            mode_r  <= MODE_MAX;
            tcmp_r  <= {W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_en && num_ok_s) begin
                        state_r <= ST_SCAN;
                        num_r   <= number;
                        mode_r  <= mode;
                        tcmp_r  <= seed_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                    end else if (start_en || end_en) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    err_r <= start_en;
                    if (en) begin
                        tcmp_r <= take_s ? t : tcmp_r;
                        cnt_r  <= (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
                    end else begin
                        tcmp_r <= tcmp_r;
                    end
                    if (end_en) begin
                        state_r <= ST_COMMIT;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SCAN;
                    end
                end
                ST_COMMIT: begin
                    err_r   <= start_en;
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Target storage: commit has priority over a clear of the same entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i <= N_TGT; i++) begin
                stored_r[i] <= {W{1'b0}};
            end
            valid_r <= {N_TGT{1'b0}};
            ttemp_r <= {W{1'b0}};
        end else begin
            ttemp_r <= rd_valid_s ? rd_val_s : {W{1'b0}};
            for (int i = 1; i <= N_TGT; i++) begin
                if ((state_r == ST_COMMIT) && (num_r == IDX_W'(i))) begin
                    stored_r[i] <= tcmp_r;
                    valid_r[i]  <= 1'b1;
                end else if (clr && (number == IDX_W'(i))) begin
                    stored_r[i] <= {W{1'b0}};
                    valid_r[i]  <= 1'b0;
                end else begin
                    stored_r[i] <= stored_r[i];
                end
            end
        end
    end

    assign ttemp = ttemp_r;
    assign tcmp  = tcmp_r;
    assign cnt   = cnt_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;

endmodule

// File: doc/textreme_targets.md
TEXTREME_TARGETS -- requirements
Module: textreme_targets

Interface
REQ-001 Parameter W, default 10, sample/extreme width in bits.
REQ-002 Parameter N_TGT, default 15, number of tracked targets (indices 1..N_TGT; 0 = no target).
REQ-003 Parameter IDX_W, default 4, index width; SHALL satisfy 2**IDX_W > N_TGT.
REQ-004 Parameter CNT_W, default 12, per-scan sample counter width.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset of all state.
REQ-007 number  in  IDX_W  target index for start/clear/readout.
REQ-008 start_en  in  1  scan start for target number.
REQ-009 en  in  1  sample t valid during scan.
REQ-010 end_en  in  1  scan end, commit result.
REQ-011 clr  in  1  synchronous clear of target number.
REQ-012 mode  in  1  0 = track maximum, 1 = track minimum; sampled at start.
REQ-013 t  in  W  sample value, unsigned.
REQ-014 ttemp  out  W  registered stored extreme of target number.
REQ-015 tcmp  out  W  running extreme of current scan.
REQ-016 busy  out  1  high in SCAN and COMMIT.
REQ-017 done  out  1  one-cycle pulse in COMMIT.
REQ-018 cnt  out  CNT_W  samples accepted in current/last scan.
REQ-019 err  out  1  one-cycle pulse on protocol violation.

Function
REQ-020 FSM states IDLE, SCAN, COMMIT; IDLE->SCAN on start_en with 1<=number<=N_TGT; SCAN->COMMIT on end_en; COMMIT->IDLE unconditionally.
REQ-021 On start: latch number to num_q, mode to mode_q; tcmp <= stored value if target valid bit set, else 0 (max) / all-ones (min); cnt <= 0.
REQ-022 In SCAN with en: tcmp <= t if t>tcmp (max) or t<tcmp (min); equal values leave tcmp unchanged; cnt increments, saturating at all-ones.
REQ-023 en and end_en in the same SCAN cycle: sample applied first, then transition to COMMIT with the updated tcmp.
REQ-024 COMMIT: stored[num_q] <= tcmp, valid[num_q] <= 1, done = 1 for exactly that cycle.
REQ-025 ttemp = stored[number] of previous cycle (1-cycle latency); 0 when number is 0 or >N_TGT or the target is not valid.
REQ-026 clr with valid number: stored <= 0, valid <= 0 for that target, in any state, next cycle.
REQ-027 clr and COMMIT on the same target in the same cycle: COMMIT wins.
REQ-028 clr on num_q during SCAN does not abort the scan; the later commit writes normally.
REQ-029 err pulses, with the event otherwise ignored, on: start_en in SCAN/COMMIT; end_en in IDLE; start_en with number 0 or >N_TGT.
REQ-030 start_en and end_en together in IDLE: start accepted, end_en ignored, no err.
REQ-031 en outside SCAN ignored, no err; tcmp and cnt hold their last values in IDLE.

Reset
REQ-032 reset low: state IDLE; all stored values 0, all valid bits 0; ttemp, tcmp, cnt = 0; busy, done, err = 0.
REQ-033 Reset mid-scan discards the scan; no target is written.

Structure
REQ-034 Shared package holds the FSM state enum and MODE_MAX/MODE_MIN constants.
REQ-035 One sub-module extreme_cmp (W-bit unsigned compare, mode-selected) SHALL perform the update decision.
REQ-036 Target storage is an N_TGT-entry register array plus valid vector; no RAM inference required.

Verification
REQ-037 Max scan target 3, fresh: start, t=5,9,2, end -> tcmp=9, done 1 cycle, cnt=3, ttemp(number=3)=9 one cycle later.
REQ-038 Min scan target 3 after REQ-037, t=12,4,7 -> commit 4; follow-up max scan with t=1 -> result 4 (seeded from stored).
REQ-039 en with t=20 and end_en in the same cycle, prior tcmp 9 -> committed value 20.
REQ-040 start_en with number=0 and end_en in IDLE -> err pulse each, busy stays 0.
REQ-041 clr target 5 coincident with commit to 5 -> stored 5 holds committed value; clr target 7 -> ttemp(7)=0.
REQ-042 reset asserted mid-scan on target 2 -> all outputs 0, stored[2] unchanged from 0, next scan starts from empty.
